// File: rtl/lock_scan_ctrl.sv
// Sequential lock-table search: streams table words past the external comparator
// and reports the first matching index (or a miss) on a valid/ready result port.
`timescale 1ns/1ps
module lock_scan_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_key,
  input  logic [ADDR_W:0]   req_count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_dout,
  output logic [WIDTH-1:0]  cmp_lock,
  output logic [WIDTH-1:0]  cmp_key,
  input  logic              cmp_match,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [ADDR_W-1:0] res_index
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t                         r_state;
  logic [ADDR_W-1:0]              r_last;
  logic [RD_LAT-1:0]              r_tag_v;
  logic [RD_LAT-1:0][ADDR_W-1:0]  r_tag_a;

  logic [ADDR_W:0]   w_n;
  logic              w_cmp_v;
  logic [ADDR_W-1:0] w_cmp_a;

  assign w_n      = (req_count > L_DEPTH) ? L_DEPTH : req_count;
  assign w_cmp_v  = r_tag_v[RD_LAT-1];
  assign w_cmp_a  = r_tag_a[RD_LAT-1];
  assign cmp_lock = mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= '0;
      r_tag_v   <= '0;
      r_tag_a   <= '0;
      req_ready <= 1'b1;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      cmp_key   <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_index <= '0;
    end else begin
      // Tag pipeline tracks each issued read so its data lines up with the compare.
      r_tag_v[0] <= mem_en;
      r_tag_a[0] <= mem_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_a[i] <= r_tag_a[i-1];
      end

      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cmp_key   <= req_key;
            req_ready <= 1'b0;
            if (w_n == '0) begin
              r_state   <= RESP;
              res_valid <= 1'b1;
              res_hit   <= 1'b0;
              res_index <= '0;
            end else begin
              r_state  <= SCAN;
              r_last   <= ADDR_W'(w_n - 1'b1);
              mem_en   <= 1'b1;
              mem_addr <= '0;
            end
          end
        end
        SCAN: begin
          if (mem_en) begin
            if (mem_addr == r_last) mem_en <= 1'b0;
            else                    mem_addr <= mem_addr + 1'b1;
          end
          if (w_cmp_v) begin
            if (cmp_match) begin
              // Drop younger reads still in flight so the lowest index wins.
              r_tag_v   <= '0;
              mem_en    <= 1'b0;
              r_state   <= RESP;
              res_valid <= 1'b1;
              res_hit   <= 1'b1;
              res_index <= w_cmp_a;
            end else if (w_cmp_a == r_last) begin
              r_state   <= RESP;
              res_valid <= 1'b1;
              res_hit   <= 1'b0;
              res_index <= '0;
            end
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
